// File: rtl/tmds_rx_channel.sv
// TMDS receive channel: word alignment from a 2-bit DDR stream, 8b/10b TMDS decode and token lock FSM.
// out_valid is a one-cycle strobe with no backpressure; all outputs hold their value between strobes.
module tmds_rx_channel #(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 4096
) (
    input  logic       clk_shift,
    input  logic       rst_n,
    input  logic [1:0] in_ddr,
    output logic       out_valid,
    output logic       out_de,
    output logic [7:0] out_data,
    output logic [1:0] out_ctrl,
    output logic [9:0] out_raw,
    output logic       locked,
    output logic [3:0] slip_pos
);
    localparam int TW = $clog2(LOCK_TOKENS + 1);
    localparam logic [TW-1:0] LT = TW'(LOCK_TOKENS);
    localparam logic [15:0]   SW = 16'(SEARCH_WORDS);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state, state_nx;
    logic [11:0]   sr;
    logic [2:0]    cnt;
    logic [TW-1:0] tok_cnt, tok_nx;
    logic [15:0]   miss_cnt, miss_nx;
    logic          extract, slip, is_tok;
    logic [9:0]    raw;
    logic [7:0]    q, dec_data;
    logic [1:0]    dec_ctrl;

    // sr[11] is the newest serial bit. Even offsets are taken one cycle late so that an
    // even offset and the next odd offset share an extraction cycle.
    assign raw     = slip_pos[0] ? sr[10:1] : sr[9:0];
    assign extract = (cnt == 3'd6);
    assign locked  = (state == LOCKED);

    always_comb begin : decode
        is_tok   = 1'b1;
        dec_ctrl = 2'b00;
        dec_data = 8'h00;
        q        = raw[9] ? ~raw[7:0] : raw[7:0];
        case (raw)
            10'h354: dec_ctrl = 2'b00;
            10'h0AB: dec_ctrl = 2'b01;
            10'h154: dec_ctrl = 2'b10;
            10'h2AB: dec_ctrl = 2'b11;
            default: is_tok   = 1'b0;
        endcase
        dec_data[0] = q[0];
        for (int i = 1; i < 8; i++)
            dec_data[i] = raw[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    always_comb begin : fsm_next
        state_nx = state;
        tok_nx   = tok_cnt;
        miss_nx  = miss_cnt;
        slip     = 1'b0;
        if (extract) begin
            if (is_tok) begin
                miss_nx = '0;
                if (tok_cnt != LT)
                    tok_nx = tok_cnt + TW'(1);
                if (state == SEARCH && tok_nx == LT)
                    state_nx = LOCKED;
            end else begin
                tok_nx  = '0;
                miss_nx = miss_cnt + 16'd1;
                if (miss_nx == SW) begin
                    miss_nx  = '0;
                    slip     = 1'b1;
                    state_nx = SEARCH;
                end
            end
        end
    end

    always_ff @(posedge clk_shift or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            state    <= SEARCH;
            tok_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nx;
            tok_cnt  <= tok_nx;
            miss_cnt <= miss_nx;
        end
    end

    // cnt runs 0..6 from reset; later words restart at 2 (5-cycle period) or at 1 when
    // an odd-to-even slip pushes the extraction one cycle later.
    always_ff @(posedge clk_shift or negedge rst_n) begin : datapath
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            slip_pos  <= '0;
            out_valid <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            out_raw   <= '0;
        end else begin
            sr        <= {in_ddr[1], in_ddr[0], sr[11:2]};
            out_valid <= extract;
            if (extract) begin
                cnt      <= (slip && slip_pos[0]) ? 3'd1 : 3'd2;
                out_raw  <= raw;
                out_de   <= ~is_tok;
                out_data <= is_tok ? 8'h00 : dec_data;
                out_ctrl <= dec_ctrl;
            end else begin
                cnt <= cnt + 3'd1;
            end
            if (slip)
                slip_pos <= (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
        end
    end
endmodule
